uart_rx_fifo: RTL and testbench

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each received byte on the receiver's single-cycle `re` or `error` strobe, tags framing/parity-failed bytes, and holds them in a show-ahead FIFO until the host side pops them. It also reports occupancy, a sticky overflow flag and a saturating error counter, so slow consumers never lose track of line problems.

---
 rtl/uart_rx_fifo.sv | 103 ++++++++++
 tb/tb_uart_rx_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead byte FIFO behind a UART receiver.
// Each entry holds {err, data}. The block also tracks occupancy, a sticky
// overflow flag and a saturating error counter.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter bit DROP_ERRORS = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_good,
    input  logic                  wr_err,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rd_err,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [7:0]            err_count,
    input  logic                  clear_status
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [8:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic [7:0]            r_err_count;

    logic w_event;
    logic w_accept;
    logic w_store;
    logic w_drop;
    logic w_pop;
    logic w_empty;
    logic w_full;
    logic w_err_sat;

    // Flags come straight from the registered count, so they only move on edges.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // A cycle with both strobes high is an error event; wr_err alone sets the tag.
    assign w_event   = wr_good | wr_err;
    assign w_accept  = w_event & ~(wr_err & DROP_ERRORS);
    assign w_pop     = rd_en & ~w_empty;
    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign w_store   = w_accept & (~w_full | rd_en);
    assign w_drop    = w_accept & w_full & ~rd_en;
    assign w_err_sat = (r_err_count == 8'hFF);

    // Storage array: no reset needed, the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_store)
            r_mem[r_wptr] <= {wr_err, wr_data};
    end

    // Pointers and occupancy; pointers wrap naturally modulo the depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_store)
                r_wptr <= r_wptr + DEPTH_LOG2'(1);
            if (w_pop)
                r_rptr <= r_rptr + DEPTH_LOG2'(1);
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Status: clear_status wins over any same-cycle set or increment.
    always_ff @(posedge clk) begin
        if (reset || clear_status) begin
            r_overflow  <= 1'b0;
            r_err_count <= 8'h00;
        end else begin
            if (w_drop)
                r_overflow <= 1'b1;
            if (wr_err && !w_err_sat)
                r_err_count <= r_err_count + 8'h01;
        end
    end

    // Show-ahead head; forced to zero while empty so the post-reset value is defined.
    assign rd_data   = w_empty ? 8'h00 : r_mem[r_rptr][7:0];
    assign rd_err    = w_empty ? 1'b0  : r_mem[r_rptr][8];
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of uart_rx_fifo. Instance a stores error
// bytes, instance b drops them; both are 4 entries deep and share stimulus.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset, wr_good, wr_err, rd_en, clear_status;
    logic [7:0] wr_data;

    logic [7:0] a_rd_data, b_rd_data, a_err_count, b_err_count;
    logic       a_rd_err, b_rd_err, a_empty, b_empty, a_full, b_full;
    logic       a_overflow, b_overflow;
    logic [2:0] a_count, b_count;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH_LOG2(2), .DROP_ERRORS(1'b0)) dut_a (
        .clk(clk), .reset(reset), .wr_good(wr_good), .wr_err(wr_err),
        .wr_data(wr_data), .rd_en(rd_en), .rd_data(a_rd_data), .rd_err(a_rd_err),
        .empty(a_empty), .full(a_full), .count(a_count), .overflow(a_overflow),
        .err_count(a_err_count), .clear_status(clear_status)
    );

    uart_rx_fifo #(.DEPTH_LOG2(2), .DROP_ERRORS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .wr_good(wr_good), .wr_err(wr_err),
        .wr_data(wr_data), .rd_en(rd_en), .rd_data(b_rd_data), .rd_err(b_rd_err),
        .empty(b_empty), .full(b_full), .count(b_count), .overflow(b_overflow),
        .err_count(b_err_count), .clear_status(clear_status)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle, so outputs reflect the state it produced.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d, input logic err);
        wr_good = ~err;
        wr_err  = err;
        wr_data = d;
        tick();
        wr_good = 1'b0;
        wr_err  = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_good = 1'b0; wr_err = 1'b0; wr_data = 8'h00;
        rd_en = 1'b0; clear_status = 1'b0;
        do_reset();

        // Reset state
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_count", a_count, 0);
        chk("rst_overflow", a_overflow, 0);
        chk("rst_err_count", a_err_count, 0);
        chk("rst_rd_data", a_rd_data, 0);
        chk("rst_rd_err", a_rd_err, 0);

        // Single write, visible the next cycle, then popped
        wr(8'h5A, 1'b0);
        chk("w1_empty", a_empty, 0);
        chk("w1_count", a_count, 1);
        chk("w1_rd_data", a_rd_data, 8'h5A);
        chk("w1_rd_err", a_rd_err, 0);
        pop();
        chk("p1_empty", a_empty, 1);
        chk("p1_count", a_count, 0);

        // Overfill: 0x05 is dropped
        for (int i = 1; i <= 5; i++) wr(8'(i), 1'b0);
        chk("ov_full", a_full, 1);
        chk("ov_count", a_count, 4);
        chk("ov_overflow", a_overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ov_rd%0d", i), a_rd_data, i);
            pop();
        end
        chk("ov_drained", a_empty, 1);
        chk("ov_sticky", a_overflow, 1);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("ov_clear", a_overflow, 0);

        // Write into a full FIFO alongside a pop
        for (int i = 0; i < 4; i++) wr(8'h11 + 8'(i), 1'b0);
        chk("fp_full", a_full, 1);
        wr_good = 1'b1; wr_data = 8'hAA; rd_en = 1'b1;
        tick();
        wr_good = 1'b0; rd_en = 1'b0;
        chk("fp_count", a_count, 4);
        chk("fp_overflow", a_overflow, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fp_rd%0d", i), a_rd_data, 8'h12 + i);
            pop();
        end
        chk("fp_last_aa", a_rd_data, 8'hAA);
        pop();
        chk("fp_empty", a_empty, 1);

        // Pointer wrap: 10 bytes streamed, reader two cycles behind
        for (int i = 0; i < 12; i++) begin
            wr_good = (i < 10);
            wr_data = 8'h20 + 8'(i);
            rd_en   = (i >= 2);
            if (i >= 2) chk($sformatf("wrap_rd%0d", i - 2), a_rd_data, 8'h20 + i - 2);
            tick();
        end
        wr_good = 1'b0; rd_en = 1'b0;
        chk("wrap_empty", a_empty, 1);
        chk("wrap_overflow", a_overflow, 0);

        // Error byte: tagged in a, dropped in b, counted in both
        do_reset();
        wr(8'h3C, 1'b1);
        chk("err_rd_err", a_rd_err, 1);
        chk("err_rd_data", a_rd_data, 8'h3C);
        chk("err_count_a", a_err_count, 1);
        chk("drop_empty_b", b_empty, 1);
        chk("drop_count_b", b_err_count, 1);
        pop();

        // Saturation, then clear racing a wr_err
        for (int i = 0; i < 300; i++) wr(8'(i), 1'b1);
        chk("sat_a", a_err_count, 255);
        chk("sat_b", b_err_count, 255);
        chk("sat_ovf", a_overflow, 1);
        wr_err = 1'b1; clear_status = 1'b1;
        tick();
        wr_err = 1'b0; clear_status = 1'b0;
        chk("clr_err_count", a_err_count, 0);
        chk("clr_overflow", a_overflow, 0);
        chk("clr_keeps_data", a_count, 4);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 3; i++) wr(8'h40 + 8'(i), 1'b0);
        chk("mid_count3", a_count, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_count0", a_count, 0);
        chk("mid_empty", a_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
